// File: rtl/handshake_pattern_gen_if.sv
// Handshake/configuration bundle for handshake_pattern_gen.
// The master drives the burst configuration; the slave (the generator) drives the transfer outputs.
interface handshake_pattern_gen_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned GAP_W  = 16,
  parameter int unsigned DLY_W  = 4
) ();
  logic              start;
  logic              abort;
  logic [7:0]        burst_len;
  logic [GAP_W-1:0]  gap;
  logic [DLY_W-1:0]  ack_delay;
  logic [DATA_W-1:0] data_init;

  logic              validdata;
  logic              acknowledge;
  logic [DATA_W-1:0] data;
  logic              busy;
  logic              done;
  logic [7:0]        sent_count;

  modport master (
    output start, abort, burst_len, gap, ack_delay, data_init,
    input  validdata, acknowledge, data, busy, done, sent_count
  );

  modport slave (
    input  start, abort, burst_len, gap, ack_delay, data_init,
    output validdata, acknowledge, data, busy, done, sent_count
  );
endinterface

// File: rtl/handshake_pattern_gen.sv
// Burst generator: emits burst_len valid/acknowledge transfers, each preceded by a
// programmable idle gap and held for a programmable acknowledge delay.
module handshake_pattern_gen #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned GAP_W  = 16,
  parameter int unsigned DLY_W  = 4
) (
  input logic                    clk,
  input logic                    rst,
  handshake_pattern_gen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [7:0]        len_q;
  logic [GAP_W-1:0]  gap_q;
  logic [DLY_W-1:0]  dly_q;
  logic [GAP_W-1:0]  gap_cnt;
  logic [DLY_W-1:0]  dly_cnt;
  logic [DATA_W-1:0] data_q;
  logic [7:0]        sent_q;

  logic              cfg_load;
  logic              gap_load;
  logic              gap_dec;
  logic              dly_load;
  logic              dly_dec;
  logic              ack_fire;
  logic [GAP_W-1:0]  gap_src;
  logic [DLY_W-1:0]  dly_src;
  logic              last_xfer;

  assign last_xfer = ((sent_q + 8'd1) == len_q);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // On the start cycle the latched config is not yet valid, so counters load from the bus.
  always_comb begin
    state_nxt = state;
    cfg_load  = 1'b0;
    gap_load  = 1'b0;
    gap_dec   = 1'b0;
    dly_load  = 1'b0;
    dly_dec   = 1'b0;
    ack_fire  = 1'b0;
    gap_src   = gap_q;
    dly_src   = dly_q;

    case (state)
      IDLE: begin
        if (bus.start) begin
          cfg_load = 1'b1;
          if (bus.burst_len == 8'd0) begin
            state_nxt = DONE;
          end else if (bus.gap == '0) begin
            state_nxt = XFER;
            dly_load  = 1'b1;
            dly_src   = bus.ack_delay;
          end else begin
            state_nxt = GAP;
            gap_load  = 1'b1;
            gap_src   = bus.gap;
          end
        end
      end

      GAP: begin
        if (bus.abort) begin
          state_nxt = IDLE;
        end else if (gap_cnt == GAP_W'(1)) begin
          state_nxt = XFER;
          dly_load  = 1'b1;
        end else begin
          gap_dec = 1'b1;
        end
      end

      XFER: begin
        if (bus.abort) begin
          state_nxt = IDLE;
        end else if (dly_cnt == '0) begin
          ack_fire = 1'b1;
          if (last_xfer) begin
            state_nxt = DONE;
          end else if (gap_q == '0) begin
            state_nxt = XFER;
            dly_load  = 1'b1;
          end else begin
            state_nxt = GAP;
            gap_load  = 1'b1;
          end
        end else begin
          dly_dec = 1'b1;
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q   <= '0;
      gap_q   <= '0;
      dly_q   <= '0;
      gap_cnt <= '0;
      dly_cnt <= '0;
      data_q  <= '0;
      sent_q  <= '0;
    end else begin
      if (cfg_load) begin
        len_q  <= bus.burst_len;
        gap_q  <= bus.gap;
        dly_q  <= bus.ack_delay;
        data_q <= bus.data_init;
        sent_q <= '0;
      end

      if (gap_load)     gap_cnt <= gap_src;
      else if (gap_dec) gap_cnt <= gap_cnt - GAP_W'(1);

      if (dly_load)     dly_cnt <= dly_src;
      else if (dly_dec) dly_cnt <= dly_cnt - DLY_W'(1);

      if (ack_fire) begin
        sent_q <= sent_q + 8'd1;
        data_q <= data_q + DATA_W'(1);
      end
    end
  end

  assign bus.validdata   = (state == XFER);
  assign bus.acknowledge = (state == XFER) && (dly_cnt == '0);
  assign bus.busy        = (state == GAP) || (state == XFER);
  assign bus.done        = (state == DONE);
  assign bus.data        = data_q;
  assign bus.sent_count  = sent_q;

  a_gap_nonzero: assert property (@(posedge clk) disable iff (rst)
    (state == GAP) |-> (gap_cnt != '0));

  a_count_bounded: assert property (@(posedge clk) disable iff (rst)
    sent_q <= len_q);

endmodule
